bringup_wb_initiator: RTL and testbench

// Wishbone classic single-transfer master that drives the wbs_* slave port of user_project_wrapper in bringup benches.

---
 rtl/bringup_wb_initiator.sv | 182 ++++++++++++++++++
 tb/tb_bringup_wb_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bringup_wb_initiator.sv
// Wishbone classic single-transfer master fed by a CMD_DEPTH-entry command FIFO; cyc rises one edge after a push into an empty FIFO.
// Responses hold until rsp_ready; no new bus cycle starts while a response is pending, and cmd_ready drops when the FIFO is full.
module bringup_wb_initiator #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int AW      = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW      = $clog2(CMD_DEPTH + 1);
  localparam int WW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

  cmd_t          fifo_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  cmd_t          head;
  logic          fifo_empty, push, pop, rsp_hs, timeout_hit;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_to_q, rsp_to_d;
  logic [15:0]   txn_q, txn_d;

  assign head        = fifo_q[rd_ptr_q];
  assign fifo_empty  = (count_q == '0);
  assign cmd_ready   = (count_q != CW'(CMD_DEPTH));
  assign push        = cmd_valid & cmd_ready;
  assign rsp_hs      = (state_q == S_RSP) & rsp_ready;
  // A pop always coincides with launching a bus cycle, from IDLE or straight out of RSP.
  assign pop         = !fifo_empty & ((state_q == S_IDLE) | rsp_hs);
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WW'(TO_LAST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wait_d    = wait_q;
    rsp_vld_d = rsp_vld_q;
    rsp_dat_d = rsp_dat_q;
    rsp_to_d  = rsp_to_q;
    txn_d     = txn_q;

    case (state_q)
      S_IDLE: ;
      S_BUS: begin
        wait_d = wait_q + WW'(1);
        // Ack takes priority over a timeout landing on the same edge.
        if (wbs_ack_i) begin
          cyc_d     = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbs_dat_i;
          rsp_to_d  = 1'b0;
          rsp_vld_d = 1'b1;
          state_d   = S_RSP;
        end else if (timeout_hit) begin
          cyc_d     = 1'b0;
          rsp_dat_d = 32'hDEAD_BEEF;
          rsp_to_d  = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          txn_d     = txn_q + 16'd1;
          rsp_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d = S_BUS;
      cyc_d   = 1'b1;
      we_d    = head.we;
      sel_d   = head.sel;
      adr_d   = head.adr;
      dat_d   = head.dat;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wait_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_to_q  <= 1'b0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wait_q    <= wait_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_to_q  <= rsp_to_d;
      txn_q     <= txn_d;
    end
  end

  assign wbs_cyc_o   = cyc_q;
  assign wbs_stb_o   = cyc_q;
  assign wbs_we_o    = we_q;
  assign wbs_sel_o   = sel_q;
  assign wbs_adr_o   = adr_q;
  assign wbs_dat_o   = dat_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_timeout = rsp_to_q;
  assign txn_count   = txn_q;
  assign busy        = (state_q != S_IDLE) | !fifo_empty;

endmodule

// File: tb/tb_bringup_wb_initiator.sv
// Directed bench for bringup_wb_initiator: write, read, backpressure, timeout, FIFO full and async reset.
module tb_bringup_wb_initiator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = 4'h0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_timeout;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic        wbs_ack_i = 1'b0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        busy;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  // Slave model: acks on the ack_after-th cycle of cyc (0 = never) and records cycle lengths.
  int          ack_after = 0;
  logic        rd_from_adr = 1'b0;
  logic [31:0] rd_data = 32'h0;
  int          cyc_cnt = 0;
  int          last_len = 0;
  int          cyc_starts = 0;

  bringup_wb_initiator #(.CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_timeout(rsp_timeout),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wbs_cyc_o) begin
      if (cyc_cnt == 0) cyc_starts = cyc_starts + 1;
      cyc_cnt   = cyc_cnt + 1;
      wbs_ack_i = (ack_after != 0) && (cyc_cnt == ack_after);
      wbs_dat_i = rd_from_adr ? ~wbs_adr_o : rd_data;
    end else begin
      if (cyc_cnt != 0) last_len = cyc_cnt;
      cyc_cnt   = 0;
      wbs_ack_i = 1'b0;
      wbs_dat_i = 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int n = 0;
    cmd_we = we; cmd_sel = 4'hF; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin step(); n++; end
    check("push_bound", 32'(n < 100), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 300) begin step(); n++; end
    check(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int starts_before;

    // Reset state
    step(); step();
    check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    check("rst_stb", 32'(wbs_stb_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step();

    // Write, acked on the third bus cycle
    ack_after = 3;
    push(1'b1, 32'h3000_0000, 32'h1234_5678);
    check("wr_latency_cyc", 32'(wbs_cyc_o), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    step();
    check("wr_cyc", 32'(wbs_cyc_o), 32'd1);
    check("wr_stb", 32'(wbs_stb_o), 32'd1);
    check("wr_we", 32'(wbs_we_o), 32'd1);
    check("wr_sel", 32'(wbs_sel_o), 32'hF);
    check("wr_adr", wbs_adr_o, 32'h3000_0000);
    check("wr_dat_o", wbs_dat_o, 32'h1234_5678);
    wait_rsp("wr_rsp_wait");
    check("wr_rsp_dat", rsp_dat, 32'h0);
    check("wr_rsp_to", 32'(rsp_timeout), 32'd0);
    check("wr_cyc_len", 32'(last_len), 32'd3);
    check("wr_txn_before", 32'(txn_count), 32'd0);
    handshake();
    check("wr_txn", 32'(txn_count), 32'd1);
    check("wr_rsp_clr", 32'(rsp_valid), 32'd0);
    check("wr_idle_busy", 32'(busy), 32'd0);

    // Read, acked on the first bus cycle
    ack_after = 1;
    rd_data   = 32'hCAFE_F00D;
    push(1'b0, 32'h3000_0004, 32'h0);
    wait_rsp("rd_rsp_wait");
    check("rd_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    check("rd_rsp_to", 32'(rsp_timeout), 32'd0);
    check("rd_cyc_len", 32'(last_len), 32'd1);

    // Backpressure: response held, queued command waits for the handshake
    rd_data = 32'h5555_AAAA;
    push(1'b0, 32'h3000_0008, 32'h0);
    starts_before = cyc_starts;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
      check("bp_no_cyc", 32'(wbs_cyc_o), 32'd0);
      step();
    end
    check("bp_no_new_start", 32'(cyc_starts), 32'(starts_before));
    handshake();
    check("bp_b2b_cyc", 32'(wbs_cyc_o), 32'd1);
    check("bp_b2b_adr", wbs_adr_o, 32'h3000_0008);
    check("bp_rsp_clr", 32'(rsp_valid), 32'd0);
    check("bp_txn", 32'(txn_count), 32'd2);
    wait_rsp("bp_rsp_wait");
    check("bp_rsp2_dat", rsp_dat, 32'h5555_AAAA);
    handshake();
    check("bp_txn2", 32'(txn_count), 32'd3);

    // Timeout after 16 cycles with no ack
    ack_after = 0;
    push(1'b0, 32'h3000_000C, 32'h0);
    wait_rsp("to_rsp_wait");
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_dat", rsp_dat, 32'hDEAD_BEEF);
    check("to_cyc_len", 32'(last_len), 32'd16);
    handshake();
    check("to_txn", 32'(txn_count), 32'd4);

    // FIFO full: one active plus four queued, sixth held off
    ack_after   = 1;
    rd_from_adr = 1'b1;
    cmd_we      = 1'b0;
    cmd_sel     = 4'hF;
    for (int k = 0; k < 6; k++) begin
      cmd_adr   = 32'h100 + 32'(4 * k);
      cmd_valid = 1'b1;
      check("full_ready_seq", 32'(cmd_ready), 32'(k < 5));
      step();
    end
    check("full_ready_hold", 32'(cmd_ready), 32'd0);
    step();
    check("full_ready_hold2", 32'(cmd_ready), 32'd0);
    check("full_first_rsp", rsp_dat, ~32'h100);
    handshake();
    check("full_ready_after_hs", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("full_sixth_taken", 32'(cmd_ready), 32'd0);
    check("full_txn", 32'(txn_count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("drain_wait");
      check("drain_dat", rsp_dat, ~(32'h104 + 32'(4 * i)));
      handshake();
    end
    check("drain_txn", 32'(txn_count), 32'd10);
    check("drain_busy", 32'(busy), 32'd0);

    // Asynchronous reset during a bus cycle with a second command queued
    ack_after   = 0;
    rd_from_adr = 1'b0;
    push(1'b0, 32'h200, 32'h0);
    push(1'b0, 32'h204, 32'h0);
    check("rst_mid_cyc_before", 32'(wbs_cyc_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_cyc", 32'(wbs_cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wbs_stb_o), 32'd0);
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_rel_ready", 32'(cmd_ready), 32'd1);
    check("rst_rel_txn", 32'(txn_count), 32'd0);
    check("rst_rel_busy", 32'(busy), 32'd0);
    check("rst_rel_cyc", 32'(wbs_cyc_o), 32'd0);

    // Normal operation after reset
    ack_after = 2;
    rd_data   = 32'h0BAD_CAFE;
    push(1'b0, 32'h300, 32'h0);
    wait_rsp("post_rst_wait");
    check("post_rst_dat", rsp_dat, 32'h0BAD_CAFE);
    check("post_rst_len", 32'(last_len), 32'd2);
    handshake();
    check("post_rst_txn", 32'(txn_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
